// File: rtl/mipi_pll_lock_ctrl.sv
// MIPI DSI PLL lock controller: pulses PLL RESET, qualifies a synchronized LOCK,
// then releases the DSI byte-domain and pixel-domain resets in order.
module mipi_pll_lock_ctrl #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 4000,
   parameter int STABLE_CYCLES = 256,
   parameter int SEQ_GAP       = 8,
   parameter int RETRY_W       = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pll_lock,
   input  logic               sw_relock,
   output logic               pll_reset,
   output logic               dsi_rst_n,
   output logic               pix_rst_n,
   output logic               ready,
   output logic               timeout_err,
   output logic [RETRY_W-1:0] retry_cnt,
   output logic [2:0]         state_o
);

   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RELEASE   = 3'd3,
      RUN       = 3'd4
   } state_e;

   // One shared counter times every state, so it must cover the longest window.
   localparam int MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_B   = (STABLE_CYCLES > SEQ_GAP) ? STABLE_CYCLES : SEQ_GAP;
   localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(SEQ_GAP - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;
   logic               timeout_err_q, timeout_err_d;
   logic               lock_meta_q, lock_s_q;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_meta_q   <= 1'b0;
         lock_s_q      <= 1'b0;
         state_q       <= RESET_PLL;
         cnt_q         <= '0;
         retry_cnt_q   <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         lock_meta_q   <= pll_lock;
         lock_s_q      <= lock_meta_q;
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         retry_cnt_q   <= retry_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d       = state_q;
      retry_cnt_d   = retry_cnt_q;
      timeout_err_d = 1'b0;

      if (sw_relock) begin
         state_d = RESET_PLL;
      end else begin
         case (state_q)
            RESET_PLL: if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            WAIT_LOCK: begin
               if (lock_s_q) begin
                  state_d = STABLE;
               end else if (cnt_q == TIMEOUT_LAST) begin
                  state_d       = RESET_PLL;
                  timeout_err_d = 1'b1;
                  if (retry_cnt_q != '1) retry_cnt_d = retry_cnt_q + RETRY_W'(1);
               end
            end
            STABLE: begin
               if (!lock_s_q)                  state_d = WAIT_LOCK;
               else if (cnt_q == STABLE_LAST)  state_d = RELEASE;
            end
            RELEASE: begin
               if (!lock_s_q)                  state_d = RESET_PLL;
               else if (cnt_q == GAP_LAST)     state_d = RUN;
            end
            RUN:     if (!lock_s_q) state_d = RESET_PLL;
            default: state_d = RESET_PLL;
         endcase
      end

      // A relock request restarts the count even when already in RESET_PLL.
      cnt_d = (sw_relock || (state_d != state_q)) ? '0 : cnt_q + CNT_W'(1);
   end

   assign pll_reset   = (state_q == RESET_PLL);
   assign dsi_rst_n   = (state_q == RELEASE) || (state_q == RUN);
   assign pix_rst_n   = (state_q == RUN);
   assign ready       = (state_q == RUN);
   assign timeout_err = timeout_err_q;
   assign retry_cnt   = retry_cnt_q;
   assign state_o     = state_q;

endmodule

// File: doc/mipi_pll_lock_ctrl.md
Name: mipi_pll_lock_ctrl

Overview:
- Sequences the MIPI DSI PLL: drives its RESET, qualifies LOCK, and releases the DSI serial/byte-domain and pixel-domain resets in order.
- Retries the PLL on lock timeout. On loss of lock or a software relock request, tears down the downstream resets and relocks.
- Runs on the free-running PLL input reference clock, upstream of the DSI colorbar/TX logic.

Parameters:
- RST_CYCLES, 16, cycles pll_reset is held high per PLL reset attempt (>=1)
- LOCK_TIMEOUT, 4000, cycles to wait for lock after pll_reset release before retrying (>=1)
- STABLE_CYCLES, 256, consecutive synchronized-lock-high cycles required before reset release (>=1)
- SEQ_GAP, 8, cycles between dsi_rst_n release and pix_rst_n release (>=1)
- RETRY_W, 4, width of retry counter

Ports:
- clk, input, 1, reference clock (same clock as PLL clkin)
- rst, input, 1, asynchronous active-high reset
- pll_lock, input, 1, PLL LOCK; asynchronous to clk
- sw_relock, input, 1, single-cycle request to force a full relock
- pll_reset, output, 1, drives PLL RESET, active-high
- dsi_rst_n, output, 1, active-low reset for the DSI serial/byte-clock domain
- pix_rst_n, output, 1, active-low reset for the pixel/colorbar domain
- ready, output, 1, high while the PLL is qualified and both domains are released
- timeout_err, output, 1, one-cycle pulse on each lock timeout
- retry_cnt, output, RETRY_W, saturating count of lock timeouts since rst
- state_o, output, 3, current FSM state encoding (debug)

Behaviour:
- Reset (rst=1, async):
  - state=RESET_PLL (0), internal counter cnt=0, sync flops=0.
  - pll_reset=1, dsi_rst_n=0, pix_rst_n=0, ready=0, timeout_err=0, retry_cnt=0.
- Lock synchronizer: pll_lock passes through a 2-flop synchronizer to give lock_s. The FSM uses only lock_s.
- Outputs are Moore-decoded from registered state; no combinational path from any input to any output:
  - pll_reset = (state==RESET_PLL)
  - dsi_rst_n = state in {RELEASE, RUN}
  - pix_rst_n = ready = (state==RUN)
- cnt clears on every state change and increments by 1 otherwise.
- States and transitions (encodings 0-4):
  - RESET_PLL(0): at cnt==RST_CYCLES-1, go to WAIT_LOCK. pll_reset is therefore high for exactly RST_CYCLES edges after rst release.
  - WAIT_LOCK(1):
    - lock_s=1: go to STABLE.
    - else at cnt==LOCK_TIMEOUT-1: go to RESET_PLL, timeout_err=1 for one cycle, retry_cnt += 1 saturating at 2^RETRY_W-1.
  - STABLE(2):
    - lock_s=0: go to WAIT_LOCK; the timeout window restarts from 0.
    - lock_s=1 and cnt==STABLE_CYCLES-1: go to RELEASE.
  - RELEASE(3): at cnt==SEQ_GAP-1, go to RUN.
  - RUN(4): hold.
- Teardown: in RELEASE or RUN, lock_s=0 goes to RESET_PLL. dsi_rst_n and pix_rst_n both drop and ready drops on the same edge.
- sw_relock=1 in any state goes to RESET_PLL with cnt=0 and takes priority over every other transition. In RESET_PLL this restarts the RST_CYCLES count. It does not change retry_cnt.
- Simultaneous events:
  - sw_relock and timeout on the same cycle: the relock wins and no timeout_err is issued.
  - lock_s drop and the STABLE completion on the same cycle: the drop wins, go to WAIT_LOCK.
- retry_cnt is never cleared except by rst; retries continue indefinitely.
- Latency: counting the first clk edge that samples pll_lock=1 as edge 1 (FSM already in WAIT_LOCK):
  - dsi_rst_n rises at edge STABLE_CYCLES+3.
  - pix_rst_n and ready rise SEQ_GAP edges later.
- Unused state encodings 5-7 go to RESET_PLL on the next edge.

Test Plan (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, SEQ_GAP=3):
- Reset and release: assert rst, pll_lock=0 -> pll_reset=1, all resets low, retry_cnt=0. Deassert rst -> pll_reset high for exactly 4 edges, then 0.
- Nominal lock: pll_lock rises during WAIT_LOCK -> dsi_rst_n=1 at edge 11, pix_rst_n=ready=1 at edge 14, state_o=4.
- Timeout and retry: pll_lock held 0 -> timeout_err pulses 1 cycle after 20 WAIT_LOCK cycles, pll_reset re-asserts for 4 cycles. After 3 timeouts retry_cnt=3; after 16 timeouts it holds at 15.
- Glitch during qualify: pll_lock high 5 cycles then low 1 cycle -> back to WAIT_LOCK, no reset release. Next release needs a full 8-cycle stable run.
- Loss of lock in RUN: drop pll_lock -> 2 sync cycles later, on one edge: dsi_rst_n=pix_rst_n=ready=0 and pll_reset=1. Then the full relock sequence repeats.
- sw_relock in RUN and mid-RESET_PLL: RUN -> teardown on the next edge. Pulse at RESET_PLL cnt=2 -> pll_reset stays high 4 more edges. retry_cnt unchanged. Relock coincident with a timeout -> no timeout_err.
